// File: rtl/multdiv_scoreboard_pkg.sv
// Shared defaults, exception codes and entry metadata for the multdiv scoreboard.
// The exception codes match the values the exception handler expects in rstatus.
package multdiv_scoreboard_pkg;

  localparam int SB_DEPTH  = 4;
  localparam int SB_TAG_W  = 2;
  localparam int SB_DATA_W = 32;

  localparam logic [4:0] SB_EXC_REG  = 5'd30;
  localparam int         SB_EXC_MULT = 4;
  localparam int         SB_EXC_DIV  = 5;

  // Per-entry control fields. The result data is kept separately because
  // its width is a parameter of the scoreboard instance.
  typedef struct packed {
    logic       exc;
    logic       isDiv;
    logic [4:0] rd;
  } sbMeta_t;

endpackage

// File: rtl/multdiv_sb_entry.sv
// One scoreboard slot: allocation, completion and retirement state for a
// single in-flight mult/div, plus destination-register compares.
module multdiv_sb_entry
  import multdiv_scoreboard_pkg::*;
#(
  parameter int DATA_W = SB_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              alloc,
  input  logic [4:0]        allocRd,
  input  logic              allocIsDiv,
  input  logic              doneWr,
  input  logic              doneExc,
  input  logic [DATA_W-1:0] doneData,
  input  logic              retire,
  input  logic [4:0]        rsA,
  input  logic [4:0]        rsB,
  input  logic [4:0]        issueRd,
  output logic              valid,
  output logic              done,
  output sbMeta_t           meta,
  output logic [DATA_W-1:0] data,
  output logic              matchA,
  output logic              matchB,
  output logic              matchIssue
);

  // NOTE: the result storage is reset along with the control bits so the
  // commit outputs, which read the head slot directly, are all zero in reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      done  <= 1'b0;
      meta  <= '0;
      data  <= '0;
    end else begin
      if (retire) begin
        valid <= 1'b0;
      end
      // Allocation only targets a free slot and completion only a busy one,
      // so at most one of these groups fires for a given slot in a cycle.
      if (alloc) begin
        valid      <= 1'b1;
        done       <= 1'b0;
        meta.exc   <= 1'b0;
        meta.isDiv <= allocIsDiv;
        meta.rd    <= allocRd;
      end
      if (doneWr) begin
        done     <= 1'b1;
        meta.exc <= doneExc;
        data     <= doneData;
      end
    end
  end

  assign matchA     = valid && (meta.rd == rsA);
  assign matchB     = valid && (meta.rd == rsB);
  assign matchIssue = valid && (meta.rd == issueRd);

endmodule

// File: rtl/multdiv_scoreboard.sv
// Multi-entry mult/div scoreboard: in-order commit of out-of-order results,
// RAW hazard detection for decode and WAW refusal at issue.
module multdiv_scoreboard
  import multdiv_scoreboard_pkg::*;
#(
  parameter int         DEPTH    = SB_DEPTH,
  parameter int         TAG_W    = SB_TAG_W,
  parameter int         DATA_W   = SB_DATA_W,
  parameter logic [4:0] EXC_REG  = SB_EXC_REG,
  parameter int         EXC_MULT = SB_EXC_MULT,
  parameter int         EXC_DIV  = SB_EXC_DIV
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic              issue_is_div,
  input  logic [4:0]        issue_rd,
  output logic              issue_ready,
  output logic [TAG_W-1:0]  issue_tag,
  input  logic              done_valid,
  input  logic [TAG_W-1:0]  done_tag,
  input  logic [DATA_W-1:0] done_data,
  input  logic              done_exc,
  input  logic [4:0]        rs_a,
  input  logic [4:0]        rs_b,
  output logic              hazard,
  input  logic              wb_free,
  output logic              commit_valid,
  output logic [4:0]        commit_rd,
  output logic [DATA_W-1:0] commit_data,
  output logic [TAG_W:0]    pending_count,
  output logic              protocol_err
);

  localparam logic [TAG_W:0] PTR_ONE  = {{TAG_W{1'b0}}, 1'b1};
  localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

  logic [TAG_W:0]    headPtr, tailPtr;
  logic [TAG_W-1:0]  headIdx, tailIdx;
  logic              full, doIssue, doneOk, protoErr;

  logic [DEPTH-1:0]  entValid, entDone;
  logic [DEPTH-1:0]  entMatchA, entMatchB, entMatchIssue;
  sbMeta_t           entMeta [DEPTH];
  logic [DATA_W-1:0] entData [DEPTH];

  assign headIdx = headPtr[TAG_W-1:0];
  assign tailIdx = tailPtr[TAG_W-1:0];

  assign pending_count = tailPtr - headPtr;
  assign full          = (pending_count == FULL_CNT);

  // Refusing a busy destination keeps at most one in-flight writer per
  // register. A slot freed by this cycle's commit is only visible next cycle.
  assign issue_ready = reset && !full && !((issue_rd != 5'd0) && (|entMatchIssue));
  assign issue_tag   = tailIdx;
  assign doIssue     = issue_valid && issue_ready;

  assign doneOk = done_valid && entValid[done_tag] && !entDone[done_tag];

  // Entries still committing this cycle stay visible, so decode never reads
  // the regfile in the same cycle the result is being written.
  assign hazard = ((rs_a != 5'd0) && (|entMatchA)) ||
                  ((rs_b != 5'd0) && (|entMatchB));

  assign commit_valid = entValid[headIdx] && entDone[headIdx] && wb_free;

  // NOTE: every output of a combinational block is given a default first so
  // no path through it can infer a latch.
  always_comb begin
    commit_rd   = entMeta[headIdx].rd;
    commit_data = entData[headIdx];
    if (entMeta[headIdx].exc) begin
      commit_rd   = EXC_REG;
      commit_data = entMeta[headIdx].isDiv ? DATA_W'(EXC_DIV) : DATA_W'(EXC_MULT);
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : gEntry
    multdiv_sb_entry #(
      .DATA_W(DATA_W)
    ) uEntry (
      .clock      (clock),
      .reset      (reset),
      .alloc      (doIssue && (tailIdx == TAG_W'(i))),
      .allocRd    (issue_rd),
      .allocIsDiv (issue_is_div),
      .doneWr     (doneOk && (done_tag == TAG_W'(i))),
      .doneExc    (done_exc),
      .doneData   (done_data),
      .retire     (commit_valid && (headIdx == TAG_W'(i))),
      .rsA        (rs_a),
      .rsB        (rs_b),
      .issueRd    (issue_rd),
      .valid      (entValid[i]),
      .done       (entDone[i]),
      .meta       (entMeta[i]),
      .data       (entData[i]),
      .matchA     (entMatchA[i]),
      .matchB     (entMatchB[i]),
      .matchIssue (entMatchIssue[i])
    );
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      headPtr  <= '0;
      tailPtr  <= '0;
      protoErr <= 1'b0;
    end else begin
      if (doIssue) begin
        tailPtr <= tailPtr + PTR_ONE;
      end
      if (commit_valid) begin
        headPtr <= headPtr + PTR_ONE;
      end
      if (done_valid && !doneOk) begin
        protoErr <= 1'b1;
      end
    end
  end

  assign protocol_err = protoErr;

endmodule

// File: tb/tb_multdiv_scoreboard.sv
// Directed bench for multdiv_scoreboard: expected commits are queued at issue
// and a negedge monitor pops and compares them whenever commit_valid is seen.
module tb_multdiv_scoreboard;

  logic        clock = 1'b0;
  logic        reset;
  logic        issue_valid, issue_is_div;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic [1:0]  issue_tag;
  logic        done_valid;
  logic [1:0]  done_tag;
  logic [31:0] done_data;
  logic        done_exc;
  logic [4:0]  rs_a, rs_b;
  logic        hazard;
  logic        wb_free;
  logic        commit_valid;
  logic [4:0]  commit_rd;
  logic [31:0] commit_data;
  logic [2:0]  pending_count;
  logic        protocol_err;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } expCommit_t;

  expCommit_t expQ[$];
  int checks = 0;
  int errors = 0;

  multdiv_scoreboard dut (
    .clock         (clock),
    .reset         (reset),
    .issue_valid   (issue_valid),
    .issue_is_div  (issue_is_div),
    .issue_rd      (issue_rd),
    .issue_ready   (issue_ready),
    .issue_tag     (issue_tag),
    .done_valid    (done_valid),
    .done_tag      (done_tag),
    .done_data     (done_data),
    .done_exc      (done_exc),
    .rs_a          (rs_a),
    .rs_b          (rs_b),
    .hazard        (hazard),
    .wb_free       (wb_free),
    .commit_valid  (commit_valid),
    .commit_rd     (commit_rd),
    .commit_data   (commit_data),
    .pending_count (pending_count),
    .protocol_err  (protocol_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one op; optionally queue the commit it must eventually produce.
  task automatic doIssue(input logic [4:0] rd, input logic isDiv, input logic [1:0] expTag,
                         input logic push, input logic [4:0] cRd, input logic [31:0] cData);
    expCommit_t e;
    issue_valid  = 1'b1;
    issue_rd     = rd;
    issue_is_div = isDiv;
    #1;
    check("issue_ready", issue_ready, 1);
    check("issue_tag", issue_tag, expTag);
    if (push) begin
      e.rd   = cRd;
      e.data = cData;
      expQ.push_back(e);
    end
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic doDone(input logic [1:0] tag, input logic [31:0] data, input logic exc);
    done_valid = 1'b1;
    done_tag   = tag;
    done_data  = data;
    done_exc   = exc;
    tick();
    done_valid = 1'b0;
    done_exc   = 1'b0;
  endtask

  task automatic waitDrain(input int maxCycles);
    int n = 0;
    while (expQ.size() != 0 && n < maxCycles) begin
      tick();
      n++;
    end
    check("drain_queue_empty", 64'(expQ.size()), 0);
  endtask

  task automatic resetDut();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    tick();
  endtask

  // Monitor: every commit the DUT presents must match the oldest expected one.
  initial begin
    expCommit_t e;
    forever begin
      @(negedge clock);
      if (reset && commit_valid) begin
        if (expQ.size() == 0) begin
          check("unexpected_commit", commit_valid, 0);
        end else begin
          e = expQ.pop_front();
          check("commit_rd", commit_rd, e.rd);
          check("commit_data", commit_data, e.data);
        end
      end
    end
  end

  initial begin
    reset        = 1'b0;
    issue_valid  = 1'b0;
    issue_is_div = 1'b0;
    issue_rd     = 5'd0;
    done_valid   = 1'b0;
    done_tag     = 2'd0;
    done_data    = 32'd0;
    done_exc     = 1'b0;
    rs_a         = 5'd0;
    rs_b         = 5'd0;
    wb_free      = 1'b1;
    #12;
    reset = 1'b1;
    tick();

    // Idle after reset
    check("idle_issue_ready", issue_ready, 1);
    check("idle_hazard", hazard, 0);
    check("idle_commit_valid", commit_valid, 0);
    check("idle_pending", pending_count, 0);
    check("idle_protocol_err", protocol_err, 0);

    // Single op: RAW hazard, commit one cycle after done, hazard clears
    doIssue(5'd5, 1'b0, 2'd0, 1'b1, 5'd5, 32'd42);
    rs_a = 5'd5;
    #1;
    check("raw_hazard_a", hazard, 1);
    check("pending_one", pending_count, 1);
    rs_a = 5'd0;
    rs_b = 5'd5;
    #1;
    check("raw_hazard_b", hazard, 1);
    check("no_commit_before_done", commit_valid, 0);
    doDone(2'd0, 32'd42, 1'b0);
    #1;
    check("commit_after_done", commit_valid, 1);
    check("hazard_while_committing", hazard, 1);
    tick();
    check("hazard_cleared", hazard, 0);
    check("pending_zero", pending_count, 0);
    rs_b = 5'd0;
    waitDrain(4);

    // Out-of-order completion, in-order commit
    resetDut();
    doIssue(5'd3, 1'b0, 2'd0, 1'b1, 5'd3, 32'd10);
    doIssue(5'd4, 1'b0, 2'd1, 1'b1, 5'd4, 32'd20);
    doIssue(5'd6, 1'b0, 2'd2, 1'b1, 5'd6, 32'd30);
    doDone(2'd2, 32'd30, 1'b0);
    #1;
    check("head_not_done_no_commit", commit_valid, 0);
    doDone(2'd0, 32'd10, 1'b0);
    doDone(2'd1, 32'd20, 1'b0);
    waitDrain(8);

    // Full, same-cycle commit does not free a slot, then wrap to tag 0
    resetDut();
    doIssue(5'd1, 1'b0, 2'd0, 1'b1, 5'd1, 32'd101);
    doIssue(5'd2, 1'b0, 2'd1, 1'b1, 5'd2, 32'd102);
    doIssue(5'd3, 1'b0, 2'd2, 1'b1, 5'd3, 32'd103);
    doIssue(5'd4, 1'b0, 2'd3, 1'b1, 5'd4, 32'd104);
    #1;
    check("full_ready_low", issue_ready, 0);
    check("full_pending", pending_count, 4);
    doDone(2'd0, 32'd101, 1'b0);
    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    #1;
    check("full_commit_valid", commit_valid, 1);
    check("full_commit_no_ready", issue_ready, 0);
    tick();
    issue_valid = 1'b0;
    #1;
    check("refused_issue_pending", pending_count, 3);
    check("wrap_tag", issue_tag, 0);
    doIssue(5'd9, 1'b0, 2'd0, 1'b1, 5'd9, 32'd109);
    check("refill_pending", pending_count, 4);
    doDone(2'd1, 32'd102, 1'b0);
    doDone(2'd2, 32'd103, 1'b0);
    doDone(2'd3, 32'd104, 1'b0);
    doDone(2'd0, 32'd109, 1'b0);
    waitDrain(8);

    // Exceptions and write-port back-pressure (pointers continue at index 1)
    doIssue(5'd7, 1'b1, 2'd1, 1'b1, 5'd30, 32'd5);
    wb_free = 1'b0;
    doDone(2'd1, 32'hdead, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("wb_busy_no_commit", commit_valid, 0);
      check("wb_busy_retained", pending_count, 1);
      tick();
    end
    wb_free = 1'b1;
    #1;
    check("div_exc_commit_valid", commit_valid, 1);
    check("div_exc_rd", commit_rd, 30);
    check("div_exc_data", commit_data, 5);
    tick();
    doIssue(5'd9, 1'b0, 2'd2, 1'b1, 5'd30, 32'd4);
    doDone(2'd2, 32'h1234, 1'b1);
    waitDrain(4);

    // Protocol error, WAW refusal, async reset mid-flight
    doDone(2'd3, 32'h55, 1'b0);
    check("protocol_err_set", protocol_err, 1);
    tick();
    check("protocol_err_sticky", protocol_err, 1);
    doIssue(5'd8, 1'b0, 2'd3, 1'b0, 5'd0, 32'd0);
    issue_rd = 5'd8;
    #1;
    check("waw_refused", issue_ready, 0);
    issue_rd = 5'd10;
    #1;
    check("other_rd_ready", issue_ready, 1);
    rs_a = 5'd8;
    #1;
    check("pending_rd8_hazard", hazard, 1);
    reset = 1'b0;
    #1;
    check("rst_pending", pending_count, 0);
    check("rst_issue_ready", issue_ready, 0);
    check("rst_hazard", hazard, 0);
    check("rst_commit_valid", commit_valid, 0);
    check("rst_commit_rd", commit_rd, 0);
    check("rst_commit_data", commit_data, 0);
    check("rst_protocol_err", protocol_err, 0);
    #1;
    reset = 1'b1;
    tick();
    check("post_rst_ready", issue_ready, 1);
    doDone(2'd3, 32'h77, 1'b0);
    check("stale_done_flagged", protocol_err, 1);
    rs_a = 5'd0;
    tick();
    check("final_queue_empty", 64'(expQ.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
